// File: rtl/fft8_frame_loader_if.sv
// fft8_frame_loader_if: sample-stream and frame-bus signals of the FFT frame loader.
// The master side is the environment: it drives samples and flush, and accepts frames.
// The slave side is the loader itself.
interface fft8_frame_loader_if #(
   parameter int DW  = 9,
   parameter int NPT = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [DW-1:0]       in_data;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [NPT*DW-1:0]   out_data;

   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
      output flush,
      input  out_valid,
      output out_ready,
      input  out_data
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
      input  flush,
      output out_valid,
      input  out_ready,
      output out_data
   );
endinterface

// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader: collects a serial stream of signed samples into 8-sample frames.
// It uses two ping-pong banks: one bank fills while the other is presented on the
// parallel bus until the FFT side takes it.
// Optional macro FFT8_BITREV_EN: when it is defined, samples are written in
// bit-reversed slot order, so out_data slot k holds sample bitrev3(k).
module fft8_frame_loader #(
   parameter int DW  = 9,
   parameter int NPT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fft8_frame_loader_if.slave    bus,
   output logic [2:0]            wr_cnt,
   output logic [7:0]            frame_cnt
);

   // The 3-bit pointers and the bit-reverse map only make sense for 8 points.
   if (NPT != 8) begin : g_npt_check
      $error("fft8_frame_loader: NPT must be 8");
   end

   logic [DW-1:0] mem [2][NPT];
   logic [1:0]    full_q, full_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [2:0]    wr_ptr_q, wr_ptr_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic [2:0]    wr_slot;
   logic          wr_fire;
   logic          out_fire;

   // Handshake qualifiers. in_ready depends only on registered state, so out_ready
   // cannot reach in_ready in the same cycle. A flush drops a write in the same cycle.
   always_comb begin
      bus.in_ready  = ~full_q[wr_bank_q];
      bus.out_valid = full_q[rd_bank_q];
      wr_fire       = bus.in_valid & ~full_q[wr_bank_q] & ~bus.flush;
      out_fire      = full_q[rd_bank_q] & bus.out_ready;
      wr_cnt        = wr_ptr_q;
      frame_cnt     = frame_cnt_q;
   end

   // Map the write pointer to a storage slot. In bit-reverse mode, the reorder is done
   // here on the write address, so the read side stays a plain bank select.
   always_comb begin
`ifdef FFT8_BITREV_EN
      wr_slot = {wr_ptr_q[0], wr_ptr_q[1], wr_ptr_q[2]};
`else
      wr_slot = wr_ptr_q;
`endif
   end

   // Next-state control for the bank flags, the bank selects, the write pointer and the frame counter.
   always_comb begin
      full_d      = full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_ptr_d    = wr_ptr_q;
      frame_cnt_d = frame_cnt_q;

      // Release the presented bank. A write and a read never target the same bank
      // in the same cycle, so both updates can apply together.
      if (out_fire) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
         frame_cnt_d       = frame_cnt_q + 8'd1;
      end

      if (bus.flush) begin
         wr_ptr_d = 3'd0;
      end else if (wr_fire) begin
         if (wr_ptr_q == 3'd7) begin
            wr_ptr_d          = 3'd0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            wr_ptr_d = wr_ptr_q + 3'd1;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q      <= 2'b00;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_ptr_q    <= 3'd0;
         frame_cnt_q <= 8'd0;
      end else begin
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_ptr_q    <= wr_ptr_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Sample storage. A flush does not need to clear a partial bank, because every
   // slot is rewritten before that bank can be marked full again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NPT; k++) begin
               mem[b][k] <= '0;
            end
         end
      end else if (wr_fire) begin
         mem[wr_bank_q][wr_slot] <= bus.in_data;
      end
   end

   // Present the read bank on the parallel frame bus, with slot k at bits [k*DW +: DW].
   always_comb begin
      bus.out_data = '0;
      for (int k = 0; k < NPT; k++) begin
         bus.out_data[k*DW +: DW] = mem[rd_bank_q][k];
      end
   end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// tb_fft8_frame_loader: directed scoreboard bench for fft8_frame_loader.
// Set FFT8_BITREV_EN when building the design in bit-reverse mode.
module tb_fft8_frame_loader;

   localparam int DW  = 9;
   localparam int NPT = 8;
   localparam int FW  = NPT * DW;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] wr_cnt;
   logic [7:0] frame_cnt;

   fft8_frame_loader_if #(.DW(DW), .NPT(NPT)) bus ();

   fft8_frame_loader #(.DW(DW), .NPT(NPT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .wr_cnt    (wr_cnt),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   int            tests = 0;
   int            fails = 0;
   logic [FW-1:0] sb_q[$];
   logic [FW-1:0] build_frame = '0;
   int            model_ptr = 0;
   logic [7:0]    model_frames = 8'd0;

   // Advance one clock; the bench both samples and drives 1 time unit after the rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int slotOf(input int n);
`ifdef FFT8_BITREV_EN
      return int'({n[0], n[1], n[2]});
`else
      return n;
`endif
   endfunction

   task automatic modelAccept(input logic [DW-1:0] d);
      build_frame[slotOf(model_ptr)*DW +: DW] = d;
      model_ptr++;
      if (model_ptr == NPT) begin
         sb_q.push_back(build_frame);
         model_ptr = 0;
      end
   endtask

   // Offer one sample and wait, with a bound, until it is accepted.
   task automatic applyStimulus(input logic [DW-1:0] d);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && n < 50) begin
         cycle();
         n++;
      end
      if (!bus.in_ready) begin
         checkOutput("accept_timeout", FW'(bus.in_ready), FW'(1));
      end else begin
         cycle();
         modelAccept(d);
      end
      bus.in_valid = 1'b0;
   endtask

   // Compare the presented frame with the scoreboard head, complete one handshake, and check frame_cnt.
   task automatic handshake(input string tag);
      logic [FW-1:0] exp;
      checkOutput({tag, "_valid"}, FW'(bus.out_valid), FW'(1));
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      checkOutput({tag, "_data"}, bus.out_data, exp);
      bus.out_ready = 1'b1;
      cycle();
      bus.out_ready = 1'b0;
      model_frames++;
      checkOutput({tag, "_frame_cnt"}, FW'(frame_cnt), FW'(model_frames));
   endtask

`ifdef FFT8_BITREV_EN
   localparam int SEQ_SLOTS [NPT] = '{1, 5, 3, 7, 2, 6, 4, 8};
`else
   localparam int SEQ_SLOTS [NPT] = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif

   initial begin
      logic [FW-1:0] exp_const;
      int            accepts;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // Reset, then check the idle state.
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      checkOutput("rst_out_valid", FW'(bus.out_valid), FW'(0));
      checkOutput("rst_in_ready", FW'(bus.in_ready), FW'(1));
      checkOutput("rst_wr_cnt", FW'(wr_cnt), FW'(0));
      checkOutput("rst_frame_cnt", FW'(frame_cnt), FW'(0));
      checkOutput("rst_out_data", bus.out_data, FW'(0));

      // Stream samples 1..8 with out_ready high. out_valid must rise one cycle after the 8th accept.
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 7; i++) applyStimulus(DW'(i));
      checkOutput("seq_wr_cnt7", FW'(wr_cnt), FW'(7));
      checkOutput("seq_valid_early", FW'(bus.out_valid), FW'(0));
      applyStimulus(DW'(8));
      for (int k = 0; k < NPT; k++) exp_const[k*DW +: DW] = DW'(SEQ_SLOTS[k]);
      checkOutput("seq_slots", bus.out_data, exp_const);
      handshake("seq");
      checkOutput("seq_valid_after", FW'(bus.out_valid), FW'(0));

      // Hold out_ready low and offer 24 samples. Only 16 samples fit into the two banks.
      accepts = 0;
      for (int i = 0; i < 24; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = DW'(20 + i);
         if (bus.in_ready) begin
            cycle();
            modelAccept(DW'(20 + i));
            accepts++;
         end else begin
            cycle();
         end
         if (i == 12) checkOutput("bp_hold_mid", bus.out_data, sb_q[0]);
      end
      bus.in_valid = 1'b0;
      checkOutput("bp_accepts", FW'(accepts), FW'(16));
      checkOutput("bp_in_ready_low", FW'(bus.in_ready), FW'(0));
      checkOutput("bp_hold_end", bus.out_data, sb_q[0]);
      bus.out_ready = 1'b1;
      #1;
      checkOutput("bp_no_comb_path", FW'(bus.in_ready), FW'(0));
      handshake("bp1");
      checkOutput("bp_in_ready_back", FW'(bus.in_ready), FW'(1));
      handshake("bp2");

      // Write a partial frame, flush it, then send a frame of -256 samples.
      for (int i = 0; i < 3; i++) applyStimulus(DW'(50 + i));
      checkOutput("fl_wr_cnt3", FW'(wr_cnt), FW'(3));
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(77);
      cycle();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      model_ptr    = 0;
      checkOutput("fl_wr_cnt0", FW'(wr_cnt), FW'(0));
      for (int i = 0; i < NPT; i++) applyStimulus(9'h100);
      checkOutput("fl_all_min", bus.out_data, {NPT{9'h100}});
      handshake("fl");

      // Accept the 8th sample of bank B in the same cycle as bank A's handshake.
      for (int i = 0; i < NPT; i++) applyStimulus(DW'(100 + i));
      for (int i = 0; i < 7; i++) applyStimulus(DW'(200 + i));
      bus.out_ready = 1'b1;
      checkOutput("sim_a_valid", FW'(bus.out_valid), FW'(1));
      checkOutput("sim_a_data", bus.out_data, sb_q.pop_front());
      applyStimulus(DW'(207));
      bus.out_ready = 1'b0;
      model_frames++;
      checkOutput("sim_frame_cnt", FW'(frame_cnt), FW'(model_frames));
      handshake("sim_b");

      // Assert reset mid-frame, with one bank full and wr_cnt at 5.
      for (int i = 0; i < NPT; i++) applyStimulus(DW'(300 + i));
      for (int i = 0; i < 5; i++) applyStimulus(DW'(400 + i));
      checkOutput("mr_wr_cnt5", FW'(wr_cnt), FW'(5));
      checkOutput("mr_valid_pre", FW'(bus.out_valid), FW'(1));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mr_out_valid", FW'(bus.out_valid), FW'(0));
      checkOutput("mr_in_ready", FW'(bus.in_ready), FW'(1));
      checkOutput("mr_wr_cnt", FW'(wr_cnt), FW'(0));
      checkOutput("mr_frame_cnt", FW'(frame_cnt), FW'(0));
      checkOutput("mr_out_data", bus.out_data, FW'(0));
      sb_q.delete();
      model_ptr    = 0;
      model_frames = 8'd0;
      cycle();
      rst_n = 1'b1;
      cycle();
      for (int i = 0; i < NPT; i++) applyStimulus(DW'(9'h1F0 + i));
      handshake("mr_clean");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fft8_frame_loader.md
Name: fft8_frame_loader

Overview:
- Upstream feeder for the 8-point radix-2 DIT FFT core.
- Accepts a serial stream of signed real samples over a valid/ready handshake and assembles them into 8-sample frames.
- Uses a two-bank ping-pong buffer, so one frame can be filled while the previous one is held stable on a parallel bus until the FFT side takes it.
- Its output bus maps directly onto the FFT's in0..in7 inputs.

Parameters:
- DW, 9, sample width in bits (two's complement; matches the FFT datapath width).
- NPT, 8, points per frame. Fixed at 8; the 3-bit pointers depend on it, and any other value is a compile-time error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data holds a valid sample
- in_ready  out  1  loader can accept a sample this cycle
- in_data  in  DW  signed input sample
- flush  in  1  synchronous; discards the partial frame in the write bank
- out_valid  out  1  a complete frame is presented on out_data
- out_ready  in  1  FFT side accepts the frame
- out_data  out  NPT*DW  frame; slot k occupies bits [k*DW +: DW]
- wr_cnt  out  3  samples held in the current partial frame (0..7)
- frame_cnt  out  8  frames handed off so far; wraps 255->0

Behaviour:
- Reset (rst_n low, asynchronous):
  - Bank full flags cleared; wr_bank=0, rd_bank=0, wr_ptr=0, frame_cnt=0.
  - Outputs: out_valid=0, in_ready=1, wr_cnt=0, out_data=0 (all bank storage cleared).
- Storage: two banks of NPT x DW registers, plus full[1:0], wr_bank, rd_bank, and wr_ptr[2:0].
- in_ready = ~full[wr_bank]. Combinational; it does not depend on in_valid.
- Write:
  - A sample is accepted when in_valid && in_ready.
  - The accepted sample is stored at bank[wr_bank][wr_ptr], and wr_ptr increments.
  - On accepting the sample at wr_ptr=7: wr_ptr wraps to 0, full[wr_bank] is set, and wr_bank toggles.
- Read side:
  - out_valid = full[rd_bank].
  - out_data is driven from bank[rd_bank] and holds stable while out_valid && !out_ready.
  - On out_valid && out_ready: full[rd_bank] clears, rd_bank toggles, and frame_cnt increments.
- Latency: the frame appears on out_data with out_valid=1 in the cycle after its 8th sample is accepted (1 clk), provided that bank is rd_bank.
- Backpressure: when both banks are full, in_ready=0 and stays 0 until an out handshake. The freed bank's in_ready rises the following cycle; no combinational path from out_ready to in_ready.
- Simultaneous 8th-sample write and out handshake in the same cycle: both take effect. The bank being read is released and the other bank becomes full; no frame is lost or duplicated.
- Flush:
  - Clears wr_ptr to 0 and discards partial data in wr_bank.
  - Full banks and any pending output frame are unaffected.
  - flush has priority over a simultaneous write: that write is dropped, although in_ready may still read 1.
- wr_cnt = wr_ptr.
- No arithmetic on sample data; samples pass through bit-exact.
- Mid-operation reset: behaves exactly as power-on reset; all partial and pending frames are lost.

Optional Feature:
- Macro: FFT8_BITREV_EN.
- When defined: out_data slot k carries sample bitrev3(k) of the frame (slot order 0,4,2,6,1,5,3,7). This serves a core that expects its inputs already bit-reversed; the reorder is done by write-address mapping, with no extra latency.
- When undefined: slot k carries sample k, in natural order.

Test Plan:
- Reset then idle:
  - out_valid=0, in_ready=1, wr_cnt=0, frame_cnt=0, out_data=0.
- Stream 1..8 with in_valid held high and out_ready=1:
  - out_valid=1 one cycle after the 8th accept.
  - Natural build: slots 0..7 = 1..8.
  - FFT8_BITREV_EN build: slots = 1,5,3,7,2,6,4,8.
  - frame_cnt reads 1 after the handshake.
- out_ready=0, stream 24 samples:
  - in_ready drops to 0 after 16 accepts, and out_data holds frame 1 stable.
  - Raise out_ready for 1 cycle: frame 2 appears and in_ready returns to 1.
- Stream 3 samples, assert flush, then stream 8 samples of -256 (9'h100):
  - wr_cnt returns to 0 on the flush.
  - The emitted frame is all 9'h100; none of the first 3 samples appear.
- With bank A full and out_ready=1, accept the 8th sample of bank B in the same cycle as A's handshake:
  - B is presented on the next cycle and frame_cnt increments by exactly 1 per handshake.
- Assert rst_n low mid-frame (wr_cnt=5, one bank full):
  - All outputs return to reset values asynchronously.
  - The next 8 samples form a clean frame.
